// File: rtl/gf_poly_eval_mp.sv
// Multi-point GF(2^m) polynomial evaluator (Horner, one coefficient per cycle per lane).
// Optional per-lane root flags behind GF_POLY_EVAL_MP_ROOT_FLAG_EN.

module gf_poly_eval_mp_mul #(
    parameter int              SYMB_W    = 8,
    parameter logic [SYMB_W:0] PRIM_POLY = 'h11D
) (
    input  logic [SYMB_W-1:0] a_i,
    input  logic [SYMB_W-1:0] b_i,
    output logic [SYMB_W-1:0] p_o
);
    logic [SYMB_W-1:0] sh;

    // Shift-and-reduce: sh tracks a_i * x^i mod PRIM_POLY.
    always_comb begin
        p_o = '0;
        sh  = a_i;
        for (int i = 0; i < SYMB_W; i++) begin
            if (b_i[i]) p_o = p_o ^ sh;
            sh = {sh[SYMB_W-2:0], 1'b0} ^ (sh[SYMB_W-1] ? PRIM_POLY[SYMB_W-1:0] : '0);
        end
    end
endmodule

module gf_poly_eval_mp #(
    parameter int              SYMB_W    = 8,
    parameter logic [SYMB_W:0] PRIM_POLY = 'h11D,
    parameter int              DEG_MAX   = 16,
    parameter int              LANES     = 4,
    parameter int              DEG_W     = $clog2(DEG_MAX+1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_vld,
    output logic                          s_rdy,
    input  logic [DEG_MAX:0][SYMB_W-1:0]  s_poly,
    input  logic [DEG_W-1:0]              s_deg,
    input  logic [LANES-1:0][SYMB_W-1:0]  s_points,
    input  logic [LANES-1:0]              s_lane_en,
    output logic                          m_vld,
    input  logic                          m_rdy,
    output logic [LANES-1:0][SYMB_W-1:0]  m_value,
    output logic [LANES-1:0]              m_lane_en,
`ifdef GF_POLY_EVAL_MP_ROOT_FLAG_EN
    output logic [LANES-1:0]              m_root,
    output logic [$clog2(LANES+1)-1:0]    m_root_cnt,
`endif
    output logic                          deg_err
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                         state_q, state_d;
    logic [DEG_MAX:0][SYMB_W-1:0]   poly_q, poly_d;
    logic [LANES-1:0][SYMB_W-1:0]   pt_q, pt_d;
    logic [LANES-1:0][SYMB_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0][SYMB_W-1:0]   mul_p;
    logic [LANES-1:0]               lane_en_q, lane_en_d;
    logic [DEG_W-1:0]               idx_q, idx_d;
    logic                           deg_err_q, deg_err_d;
    logic [DEG_W-1:0]               deg_sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf_poly_eval_mp_mul #(.SYMB_W(SYMB_W), .PRIM_POLY(PRIM_POLY)) u_mul (
            .a_i (acc_q[k]),
            .b_i (pt_q[k]),
            .p_o (mul_p[k])
        );
    end

    assign deg_sat = (s_deg > DEG_W'(DEG_MAX)) ? DEG_W'(DEG_MAX) : s_deg;

    always_comb begin
        state_d   = state_q;
        poly_d    = poly_q;
        pt_d      = pt_q;
        acc_d     = acc_q;
        lane_en_d = lane_en_q;
        idx_d     = idx_q;
        deg_err_d = deg_err_q;
        case (state_q)
            IDLE: begin
                if (s_vld) begin
                    poly_d    = s_poly;
                    pt_d      = s_points;
                    lane_en_d = s_lane_en;
                    for (int k = 0; k < LANES; k++) acc_d[k] = s_poly[deg_sat];
                    idx_d     = deg_sat - 1'b1;
                    if (s_deg > DEG_W'(DEG_MAX)) deg_err_d = 1'b1;
                    state_d   = (deg_sat == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                for (int k = 0; k < LANES; k++) acc_d[k] = mul_p[k] ^ poly_q[idx_q];
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) state_d = DONE;
            end
            DONE: begin
                if (m_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            poly_q    <= '0;
            pt_q      <= '0;
            acc_q     <= '0;
            lane_en_q <= '0;
            idx_q     <= '0;
            deg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            poly_q    <= poly_d;
            pt_q      <= pt_d;
            acc_q     <= acc_d;
            lane_en_q <= lane_en_d;
            idx_q     <= idx_d;
            deg_err_q <= deg_err_d;
        end
    end

    // Reset is folded in so the block never looks ready while held in reset.
    assign s_rdy     = (state_q == IDLE) & aresetn;
    assign m_vld     = (state_q == DONE);
    assign m_lane_en = lane_en_q;
    assign deg_err   = deg_err_q;

    always_comb begin
        m_value = '0;
        for (int k = 0; k < LANES; k++)
            if (m_vld && lane_en_q[k]) m_value[k] = acc_q[k];
    end

`ifdef GF_POLY_EVAL_MP_ROOT_FLAG_EN
    localparam int RC_W = $clog2(LANES+1);

    logic [LANES-1:0] root_q, root_d;
    logic [RC_W-1:0]  cnt_q, cnt_d;

    // Captured from the final accumulator values on the transition into DONE.
    always_comb begin
        root_d = root_q;
        cnt_d  = cnt_q;
        if (state_q != DONE && state_d == DONE) begin
            cnt_d = '0;
            for (int k = 0; k < LANES; k++) begin
                root_d[k] = lane_en_d[k] & (acc_d[k] == '0);
                cnt_d     = cnt_d + RC_W'(root_d[k]);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            root_q <= '0;
            cnt_q  <= '0;
        end else begin
            root_q <= root_d;
            cnt_q  <= cnt_d;
        end
    end

    assign m_root     = root_q;
    assign m_root_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_gf_poly_eval_mp.sv
// Scoreboard bench for gf_poly_eval_mp with the default parameter set.
module tb_gf_poly_eval_mp;
    localparam int       SYMB_W  = 8;
    localparam int       DEG_MAX = 16;
    localparam int       LANES   = 4;
    localparam int       DEG_W   = 5;
    localparam logic [8:0] PRIM  = 9'h11D;

    typedef logic [DEG_MAX:0][SYMB_W-1:0] poly_t;
    typedef logic [LANES-1:0][SYMB_W-1:0] vec_t;

    typedef struct {
        vec_t             val;
        logic [LANES-1:0] en;
        logic [LANES-1:0] root;
        int               cnt;
        int               lat;
        int               acc;
    } exp_t;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             s_vld;
    logic             s_rdy;
    poly_t            s_poly;
    logic [DEG_W-1:0] s_deg;
    vec_t             s_points;
    logic [LANES-1:0] s_lane_en;
    logic             m_vld;
    logic             m_rdy;
    vec_t             m_value;
    logic [LANES-1:0] m_lane_en;
    logic             deg_err;
`ifdef GF_POLY_EVAL_MP_ROOT_FLAG_EN
    logic [LANES-1:0] m_root;
    logic [2:0]       m_root_cnt;
`endif

    gf_poly_eval_mp dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_poly(s_poly), .s_deg(s_deg),
        .s_points(s_points), .s_lane_en(s_lane_en),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_value(m_value), .m_lane_en(m_lane_en),
`ifdef GF_POLY_EVAL_MP_ROOT_FLAG_EN
        .m_root(m_root), .m_root_cnt(m_root_cnt),
`endif
        .deg_err(deg_err)
    );

    always #5 aclk = ~aclk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t last_val;
    logic [LANES-1:0] last_en;

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference multiply: full carry-less product, then reduce.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) if (b[i]) t = t ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (t[i]) t = t ^ (15'(PRIM) << (i - 8));
        return t[7:0];
    endfunction

    function automatic logic [7:0] peval(input poly_t p, input int d, input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = d; i >= 0; i--) r = gmul(r, x) ^ p[i];
        return r;
    endfunction

    task automatic send(input poly_t p, input int deg, input vec_t pts, input logic [LANES-1:0] en);
        exp_t e;
        int   d;
        bit   ok;
        logic [7:0] v;
        @(posedge aclk); #1;
        s_poly = p; s_deg = DEG_W'(deg); s_points = pts; s_lane_en = en; s_vld = 1'b1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (s_rdy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: s_rdy=%b required 1", s_rdy);
        end else begin
            d = (deg > DEG_MAX) ? DEG_MAX : deg;
            e.val = '0; e.root = '0; e.cnt = 0;
            for (int k = 0; k < LANES; k++) begin
                v = peval(p, d, pts[k]);
                if (en[k]) e.val[k] = v;
                e.root[k] = en[k] & (v == 8'h00);
                e.cnt += int'(e.root[k]);
            end
            e.en = en; e.lat = d + 1; e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge aclk); #1;
        s_vld = 1'b0;
    endtask

    // hold > 0: caller has m_rdy low; keep it low for hold cycles once m_vld shows.
    task automatic receive(input string tag, input int hold);
        exp_t e;
        bit   got;
        got = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge aclk);
            if (m_vld) begin got = 1; break; end
        end
        n_chk++;
        if (!got || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: m_vld=%b queued=%0d", tag, m_vld, sb.size());
            if (sb.size() > 0) void'(sb.pop_front());
            m_rdy = 1'b1;
            return;
        end
        e = sb.pop_front();
        last_val = m_value; last_en = m_lane_en;
        if (cyc - e.acc !== e.lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", tag, cyc - e.acc, e.lat);
        end
        n_chk++;
        if (m_value !== e.val) begin
            n_fail++;
            $display("FAIL %s_value: got %h required %h", tag, m_value, e.val);
        end
        n_chk++;
        if (m_lane_en !== e.en) begin
            n_fail++;
            $display("FAIL %s_lane_en: got %b required %b", tag, m_lane_en, e.en);
        end
`ifdef GF_POLY_EVAL_MP_ROOT_FLAG_EN
        n_chk++;
        if (m_root !== e.root || int'(m_root_cnt) != e.cnt) begin
            n_fail++;
            $display("FAIL %s_root: got %b/%0d required %b/%0d", tag, m_root, m_root_cnt, e.root, e.cnt);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            n_chk++;
            if (m_vld !== 1'b1 || m_value !== e.val || s_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold: vld=%b val=%h rdy=%b required 1/%h/0", tag, m_vld, m_value, s_rdy, e.val);
            end
        end
        if (hold > 0) begin
            m_rdy = 1'b1;
            @(negedge aclk);
            n_chk++;
            if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_release: rdy=%b vld=%b required 1/0", tag, s_rdy, m_vld);
            end
        end else begin
            @(posedge aclk); #1;
        end
    endtask

    function automatic poly_t poly_x2p1();
        poly_t p;
        p = '0; p[0] = 8'h01; p[2] = 8'h01;
        return p;
    endfunction

    task automatic test_reset();
        aresetn = 1'b0; s_vld = 1'b0; m_rdy = 1'b1;
        s_poly = '0; s_deg = '0; s_points = '0; s_lane_en = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_chk++;
        if (s_rdy !== 1'b0 || m_vld !== 1'b0 || m_value !== '0 || m_lane_en !== '0 || deg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b val=%h en=%b err=%b required all 0",
                     s_rdy, m_vld, m_value, m_lane_en, deg_err);
        end
        aresetn = 1'b1; #1;
        n_chk++;
        if (s_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_rdy: got %b required 1", s_rdy);
        end
    endtask

    task automatic test_basic();
        send(poly_x2p1(), 2, {8'h00, 8'h80, 8'h02, 8'h01}, 4'b1111);
        receive("basic", 0);
        n_chk++;
        if (last_val !== 32'h01120500) begin
            n_fail++;
            $display("FAIL basic_const: got %h required 01120500", last_val);
        end
    endtask

    task automatic test_deg0();
        poly_t p;
        p = '0; p[0] = 8'h5A; p[1] = 8'hFF;
        send(p, 0, {8'h33, 8'h00, 8'hC7, 8'h01}, 4'b1111);
        receive("deg0", 0);
        n_chk++;
        if (last_val !== {4{8'h5A}}) begin
            n_fail++;
            $display("FAIL deg0_const: got %h required 5a5a5a5a", last_val);
        end
    endtask

    task automatic test_lane_en();
        send(poly_x2p1(), 2, {8'h00, 8'h80, 8'h02, 8'h01}, 4'b0101);
        receive("lane_en", 0);
        n_chk++;
        if (last_val !== 32'h00120000 || last_en !== 4'b0101) begin
            n_fail++;
            $display("FAIL lane_en_const: got %h/%b required 00120000/0101", last_val, last_en);
        end
    endtask

    task automatic test_backpressure();
        m_rdy = 1'b0;
        send(poly_x2p1(), 2, {8'h07, 8'h80, 8'h02, 8'h03}, 4'b1111);
        receive("bp", 3);
        send(poly_x2p1(), 2, {8'h00, 8'h80, 8'h02, 8'h01}, 4'b1011);
        receive("bp_next", 0);
    endtask

    task automatic test_deg_err();
        poly_t p;
        n_chk++;
        if (deg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL deg_err_pre: got %b required 0", deg_err);
        end
        for (int i = 0; i <= DEG_MAX; i++) p[i] = 8'(i * 37 + 11);
        send(p, 20, {8'h02, 8'h1D, 8'hFF, 8'h00}, 4'b1111);
        receive("deg_err", 0);
        n_chk++;
        if (deg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL deg_err_set: got %b required 1", deg_err);
        end
        p = '0;
        send(p, 5, {8'h02, 8'h1D, 8'hFF, 8'h00}, 4'b0111);
        receive("zero_poly", 0);
        n_chk++;
        if (deg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL deg_err_sticky: got %b required 1", deg_err);
        end
    endtask

    task automatic test_mid_reset();
        poly_t p;
        for (int i = 0; i <= DEG_MAX; i++) p[i] = 8'($urandom);
        send(p, 10, {8'h11, 8'h22, 8'h33, 8'h44}, 4'b1111);
        repeat (4) @(negedge aclk);
        aresetn = 1'b0; #1;
        n_chk++;
        if (m_vld !== 1'b0 || deg_err !== 1'b0 || s_rdy !== 1'b0 || m_value !== '0 || m_lane_en !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: vld=%b err=%b rdy=%b val=%h en=%b required all 0",
                     m_vld, deg_err, s_rdy, m_value, m_lane_en);
        end
        sb.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1; #1;
        n_chk++;
        if (s_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_rdy: got %b required 1", s_rdy);
        end
        send(poly_x2p1(), 2, {8'h00, 8'h80, 8'h02, 8'h01}, 4'b1111);
        receive("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        poly_t p;
        vec_t  pts;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i <= DEG_MAX; i++) p[i] = 8'($urandom);
            pts = vec_t'($urandom);
            if (t == 3) pts[1] = 8'h00;
            send(p, int'($urandom_range(0, DEG_MAX)), pts, 4'($urandom));
            receive("b2b", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deg0();
        test_lane_en();
        test_backpressure();
        test_deg_err();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
